jump_encoder: RTL and testbench
===============================

// Module: jump_encoder
// PURPOSE
//  Inverse of the jump-target path: turns an absolute jump target plus the current PC into a J-type instruction word.
//  Word format: {opcode, Target[27:2]}; opcode is j (0x02) or jal (0x03).
//  Checks that the target is encodable, i.e. that {PCOut[31:28], imm26, 2'b00} reproduces it exactly.
//  Sits between the test-program generator / debug loader and instruction memory.
//  Valid/ready on both sides, with a small output FIFO.
// PARAMETERS
//  DEPTH   2      output FIFO entries; power of 2, >= 2
//  CNT_W   16     width of the saturating statistics counters
//  OP_J    6'h02  opcode emitted when InLink=0
//  OP_JAL  6'h03  opcode emitted when InLink=1
// PORTS
//  Clk       in   1      clock, rising edge
//  Reset     in   1      asynchronous, active-low reset
//  InValid   in   1      request valid
//  InReady   out  1      request accepted when InValid & InReady
//  Target    in   32     absolute jump target address
//  PCOut     in   32     PC value whose [31:28] supplies the jump region
//  InLink    in   1      1 = encode jal, 0 = encode j
//  OutValid  out  1      FIFO head valid
//  OutReady  in   1      consumer takes the head when OutValid & OutReady
//  Instr     out  32     encoded instruction word (FIFO head)
//  OutErr    out  1      head entry failed encoding
//  ErrCode   out  2      [0] misaligned target, [1] region mismatch (head entry)
//  EncCount  out  CNT_W  good encodes accepted, saturating
//  ErrCount  out  CNT_W  failed encodes accepted, saturating
// BEHAVIOUR
//  Reset (Reset=0, async): FIFO emptied; OutValid=0, InReady=0; Instr=0, OutErr=0, ErrCode=0;
//    EncCount=0, ErrCount=0. InReady rises on the first clock edge after Reset deasserts.
//  Encoding is combinational on the inputs and captured into the FIFO on accept:
//    align  = (Target[1:0] != 2'b00)
//    region = (Target[31:28] != PCOut[31:28])
//    good: Instr = {InLink ? OP_JAL : OP_J, Target[27:2]}, OutErr=0, ErrCode=2'b00
//    bad:  Instr = 32'h0000_0000 (nop), OutErr=1, ErrCode={region, align}
//  Latency: an entry accepted at edge N is visible with OutValid=1 after edge N. No same-cycle bypass.
//  FIFO: InReady = (count < DEPTH); pointers wrap modulo DEPTH; strict in-order delivery.
//    Push and pop in the same cycle with count in 1..DEPTH-1: count unchanged, both occur.
//    Full: InReady=0, so no push occurs even if a pop happens in that cycle (no fall-through when full).
//    Empty: OutValid=0, and OutReady is ignored.
//  Instr, OutErr and ErrCode are held stable while OutValid & !OutReady.
//  Counters increment on accept (not on delivery): EncCount for good entries, ErrCount for bad.
//    Each counter holds at 2^CNT_W-1.
//  Inputs are don't-care when InValid=0. No state machine beyond the FIFO pointers and count.
//  Reset asserted mid-operation discards all queued entries; no partial output.
// TESTING
//  T1: Target=0x0040_0024, PCOut=0x0040_0010, InLink=0 -> after 1 edge Instr=0x0810_0009, OutErr=0, EncCount=1.
//  T2: Target=0x0FFF_FFFC, PCOut=0x0000_0000, InLink=1 -> Instr=0x0FFF_FFFF. Decode with {PCOut[31:28],imm,00} gives back 0x0FFF_FFFC.
//  T3: Target=0x1000_0000, PCOut=0x0FFF_FFFC -> Instr=0, OutErr=1, ErrCode=2'b10, ErrCount=1, EncCount unchanged.
//  T4: Target=0x0040_0026 -> ErrCode=2'b01; Target=0x2000_0002 with PCOut=0 -> ErrCode=2'b11.
//  T5: OutReady=0, three back-to-back requests A,B,C -> InReady=0 after 2 accepts, C held.
//      Raise OutReady -> A,B,C delivered in order; Instr stable while stalled.
//  T6: Assert Reset with 2 entries queued -> OutValid=0 and counters=0 immediately (no clock).
//      First request after release delivered normally.

Source files
------------

// File: rtl/jump_encoder_if.sv
// Request/response bundle for jump_encoder: request side, FIFO head and statistics.
// The master modport drives requests and OutReady; the slave modport is the encoder.
interface jump_encoder_if #(
    parameter int CNT_W = 16
);
    logic             InValid;
    logic             InReady;
    logic [31:0]      Target;
    logic [31:0]      PCOut;
    logic             InLink;
    logic             OutValid;
    logic             OutReady;
    logic [31:0]      Instr;
    logic             OutErr;
    logic [1:0]       ErrCode;
    logic [CNT_W-1:0] EncCount;
    logic [CNT_W-1:0] ErrCount;

    modport master (
        output InValid, Target, PCOut, InLink, OutReady,
        input  InReady, OutValid, Instr, OutErr, ErrCode, EncCount, ErrCount
    );

    modport slave (
        input  InValid, Target, PCOut, InLink, OutReady,
        output InReady, OutValid, Instr, OutErr, ErrCode, EncCount, ErrCount
    );
endinterface

// File: rtl/jump_encoder.sv
// Encodes an absolute jump target into a J-type word {opcode, Target[27:2]},
// flags targets that cannot be reproduced from the PC region, and queues results.
module jump_encoder #(
    parameter int           DEPTH  = 2,
    parameter int           CNT_W  = 16,
    parameter logic [5:0]   OP_J   = 6'h02,
    parameter logic [5:0]   OP_JAL = 6'h03
) (
    input  logic           Clk,
    input  logic           Reset,
    jump_encoder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
        logic [1:0]  code;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           enc;
    entry_t           head;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             rdy_en;
    logic             push, pop;
    logic             align, region;
    logic [CNT_W-1:0] enc_cnt, err_cnt;

    // Encoding is purely combinational on the request; the FIFO captures it on accept.
    always_comb begin
        align  = (bus.Target[1:0] != 2'b00);
        region = (bus.Target[31:28] != bus.PCOut[31:28]);
        enc    = '0;
        if (align || region) begin
            enc.err  = 1'b1;
            enc.code = {region, align};
        end else begin
            enc.instr = {(bus.InLink ? OP_JAL : OP_J), bus.Target[27:2]};
        end
    end

    // rdy_en keeps InReady low until the first edge after reset release.
    assign bus.InReady  = rdy_en && (count < DEPTH_C);
    assign bus.OutValid = (count != '0);
    assign push         = bus.InValid && bus.InReady;
    assign pop          = bus.OutValid && bus.OutReady;

    assign head         = mem[rd_ptr];
    assign bus.Instr    = bus.OutValid ? head.instr : 32'h0;
    assign bus.OutErr   = bus.OutValid ? head.err   : 1'b0;
    assign bus.ErrCode  = bus.OutValid ? head.code  : 2'b00;
    assign bus.EncCount = enc_cnt;
    assign bus.ErrCount = err_cnt;

    always_ff @(posedge Clk) begin
        if (push) mem[wr_ptr] <= enc;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Statistics count accepts, not deliveries, and stick at all-ones.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            enc_cnt <= '0;
            err_cnt <= '0;
        end else if (push) begin
            if (!enc.err && enc_cnt != '1) enc_cnt <= enc_cnt + 1'b1;
            if (enc.err  && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_jump_encoder.sv
// Directed plus randomized checks of jump_encoder against a queue-based reference model.
module tb_jump_encoder;
    localparam int CW    = 4;
    localparam int DEPTH = 2;
    localparam int CMAX  = (1 << CW) - 1;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    jump_encoder_if #(.CNT_W(CW)) bus ();

    jump_encoder #(.DEPTH(DEPTH), .CNT_W(CW)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic [1:0]  code;
    } exp_t;

    exp_t        q[$];
    logic [31:0] got[$];
    int          enc_n, err_n;
    bit          mrdy;
    int          tests, fails;

    // Reference encoding from the address rules, with plain arithmetic.
    function automatic exp_t model(logic [31:0] t, logic [31:0] pc, logic link);
        exp_t e;
        bit mis  = (t % 4) != 0;
        bit regn = (t / 32'h1000_0000) != (pc / 32'h1000_0000);
        if (mis || regn) begin
            e.instr = 32'h0;
            e.err   = 1'b1;
            e.code  = {regn, mis};
        end else begin
            e.instr = (link ? 32'd3 : 32'd2) * 32'h0400_0000 + (t % 32'h1000_0000) / 4;
            e.err   = 1'b0;
            e.code  = 2'b00;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("in_ready",  bus.InReady,  (mrdy && q.size() < DEPTH) ? 1 : 0);
        chk("out_valid", bus.OutValid, (q.size() > 0) ? 1 : 0);
        if (q.size() > 0) begin
            chk("instr",    bus.Instr,   q[0].instr);
            chk("out_err",  bus.OutErr,  q[0].err);
            chk("err_code", bus.ErrCode, q[0].code);
        end else begin
            chk("instr_idle", bus.Instr,   0);
            chk("err_idle",   bus.OutErr,  0);
            chk("code_idle",  bus.ErrCode, 0);
        end
        chk("enc_count", bus.EncCount, enc_n);
        chk("err_count", bus.ErrCount, err_n);
    endtask

    // Check, advance the model by one edge, then move to just past that edge.
    task automatic tick();
        bit rdy, push, pop;
        exp_t e;
        check_outputs();
        rdy  = mrdy && q.size() < DEPTH;
        push = bus.InValid && rdy;
        pop  = (q.size() > 0) && bus.OutReady;
        if (pop) begin
            got.push_back(q[0].instr);
            void'(q.pop_front());
        end
        if (push) begin
            e = model(bus.Target, bus.PCOut, bus.InLink);
            q.push_back(e);
            if (e.err) begin if (err_n < CMAX) err_n++; end
            else       begin if (enc_n < CMAX) enc_n++; end
        end
        @(posedge Clk);
        #1;
        if (Reset) mrdy = 1'b1;
    endtask

    task automatic req(input logic [31:0] t, input logic [31:0] pc, input logic link);
        bus.InValid = 1'b1;
        bus.Target  = t;
        bus.PCOut   = pc;
        bus.InLink  = link;
    endtask

    task automatic idle();
        bus.InValid = 1'b0;
    endtask

    // Queue one request while the consumer stalls, leaving it at the head.
    task automatic one(input logic [31:0] t, input logic [31:0] pc, input logic link);
        bus.OutReady = 1'b0;
        req(t, pc, link);
        tick();
        idle();
    endtask

    task automatic drain();
        bus.OutReady = 1'b1;
        tick();
        bus.OutReady = 1'b0;
    endtask

    task automatic clear_model();
        q.delete();
        enc_n = 0;
        err_n = 0;
        mrdy  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dec, iv, pv, t, pc;
        int kind;
        tests = 0;
        fails = 0;
        clear_model();
        Reset        = 1'b0;
        bus.InValid  = 1'b0;
        bus.OutReady = 1'b0;
        bus.Target   = '0;
        bus.PCOut    = '0;
        bus.InLink   = 1'b0;
        #12;
        chk("rst_out_valid", bus.OutValid, 0);
        chk("rst_in_ready",  bus.InReady,  0);
        chk("rst_instr",     bus.Instr,    0);
        chk("rst_enc_count", bus.EncCount, 0);
        chk("rst_err_count", bus.ErrCount, 0);
        Reset = 1'b1;
        tick();

        // T1 / T2: good encodes, j then jal
        one(32'h0040_0024, 32'h0040_0010, 1'b0);
        chk("t1_instr", bus.Instr,    32'h0810_0009);
        chk("t1_err",   bus.OutErr,   0);
        chk("t1_enc",   bus.EncCount, 1);
        drain();
        one(32'h0FFF_FFFC, 32'h0000_0000, 1'b1);
        chk("t2_instr", bus.Instr, 32'h0FFF_FFFF);
        iv  = bus.Instr;
        pv  = 32'h0000_0000;
        dec = {pv[31:28], iv[25:0], 2'b00};
        chk("t2_decode", dec, 32'h0FFF_FFFC);
        drain();

        // T3 / T4: region, misaligned, both
        one(32'h1000_0000, 32'h0FFF_FFFC, 1'b0);
        chk("t3_instr", bus.Instr,    0);
        chk("t3_err",   bus.OutErr,   1);
        chk("t3_code",  bus.ErrCode,  2'b10);
        chk("t3_errc",  bus.ErrCount, 1);
        chk("t3_encc",  bus.EncCount, 2);
        drain();
        one(32'h0040_0026, 32'h0040_0010, 1'b0);
        chk("t4_code_align", bus.ErrCode, 2'b01);
        drain();
        one(32'h2000_0002, 32'h0000_0000, 1'b1);
        chk("t4_code_both", bus.ErrCode, 2'b11);
        drain();

        // T5: stalled consumer, FIFO fills, C held until room frees up
        got.delete();
        bus.OutReady = 1'b0;
        req(32'h0000_0100, 32'h0, 1'b0); tick();
        req(32'h0000_0200, 32'h0, 1'b1); tick();
        req(32'h0000_0300, 32'h0, 1'b0);
        chk("t5_full_ready", bus.InReady, 0);
        tick();
        chk("t5_hold_instr", bus.Instr, 32'h0800_0040);
        tick();
        bus.OutReady = 1'b1;
        tick();
        tick();
        idle();
        for (int i = 0; i < 3; i++) tick();
        chk("t5_count", got.size(), 3);
        if (got.size() == 3) begin
            chk("t5_first",  got[0], 32'h0800_0040);
            chk("t5_second", got[1], 32'h0C00_0080);
            chk("t5_third",  got[2], 32'h0800_00C0);
        end
        chk("t5_enc", bus.EncCount, 5);

        // T6: asynchronous reset with two entries queued
        bus.OutReady = 1'b0;
        req(32'h0000_0400, 32'h0, 1'b0); tick();
        req(32'h0000_0500, 32'h0, 1'b0); tick();
        idle();
        chk("t6_pre_valid", bus.OutValid, 1);
        Reset = 1'b0;
        #2;
        chk("t6_valid", bus.OutValid, 0);
        chk("t6_ready", bus.InReady,  0);
        chk("t6_encc",  bus.EncCount, 0);
        chk("t6_errc",  bus.ErrCount, 0);
        chk("t6_instr", bus.Instr,    0);
        clear_model();
        Reset = 1'b1;
        tick();
        one(32'h0040_0024, 32'h0040_0010, 1'b1);
        chk("t6_after", bus.Instr, 32'h0C10_0009);
        drain();

        // Randomized traffic mixing good, misaligned and off-region targets
        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 3);
            pc   = $urandom;
            t    = {pc[31:28], 28'($urandom)};
            if (kind != 1) t[1:0] = 2'b00;
            if (kind == 2) t[31:28] = pc[31:28] + 4'd1;
            bus.InValid  = ($urandom_range(0, 3) != 0);
            bus.Target   = t;
            bus.PCOut    = pc;
            bus.InLink   = $urandom_range(0, 1) == 1;
            bus.OutReady = ($urandom_range(0, 2) != 0);
            tick();
        end

        // Saturation of the good-encode counter
        bus.OutReady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            req(32'h0000_0010 + 32'(i) * 4, 32'h0, 1'b0);
            tick();
        end
        idle();
        tick();
        chk("sat_enc", bus.EncCount, CMAX);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
